out_port_ctrl: RTL and testbench
================================

OUT_PORT_CTRL -- requirements
Module: out_port_ctrl

Interface
REQ-001 The block SHALL have parameter TO_CYCLES, default 255: cycles WAIT_ACK waits for ACK before abort (used only with OUT_TIMEOUT_EN).
REQ-002 The block SHALL have port CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 The block SHALL have port CLR  input  1  reset; asynchronous, active-low.
REQ-004 The block SHALL have port WBUS  input  8  data from W bus, captured on an accepted request.
REQ-005 The block SHALL have port OUT_req  input  1  OUT-byte request from the sequencer, level-sampled each edge.
REQ-006 The block SHALL have port PORT_sel  input  1  target select: 0 = port 3 (hex display), 1 = port 4 (serial).
REQ-007 The block SHALL have port ACK  input  1  external device acknowledge for port 4.
REQ-008 The block SHALL have port Lo3  output  1  one-cycle load strobe for port 3.
REQ-009 The block SHALL have port P3_DATA  output  8  captured byte presented to port 3.
REQ-010 The block SHALL have port READY  output  1  port 4 byte available, awaiting ACK.
REQ-011 The block SHALL have port SER_OUT  output  1  port 4 serial data, LSB first, idle high.
REQ-012 The block SHALL have port SER_VALID  output  1  high while SER_OUT carries a data bit.
REQ-013 The block SHALL have port BUSY  output  1  high in every state except IDLE; sequencer holds off.
REQ-014 The block SHALL have port TIMEOUT  output  1  sticky ACK-timeout flag.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD3, WAIT_ACK and SHIFT, with IDLE entered on reset.
REQ-016 In IDLE, an edge with OUT_req=1 SHALL capture WBUS into the data register and go to LOAD3 (PORT_sel=0) or WAIT_ACK (PORT_sel=1).
REQ-017 OUT_req while BUSY=1 SHALL be ignored: no capture, no state change, no queuing.
REQ-018 In LOAD3, Lo3 SHALL be 1 for exactly one cycle with P3_DATA equal to the captured byte, and the next state SHALL be IDLE.
REQ-019 P3_DATA SHALL hold the last byte captured for port 3 until the next port-3 capture.
REQ-020 In WAIT_ACK, READY SHALL be 1, and an edge with ACK=1 SHALL go to SHIFT with bit counter = 0.
REQ-021 In SHIFT: SER_VALID=1, SER_OUT=data[count], and count increments each edge; after count 7 the next state SHALL be IDLE, giving 8 SHIFT cycles.
REQ-022 READY SHALL be 0 in SHIFT; SER_OUT SHALL be 1 and SER_VALID 0 outside SHIFT.
REQ-023 ACK SHALL be ignored outside WAIT_ACK, including in the same IDLE cycle as OUT_req.
REQ-024 Latency SHALL be: port 3, Lo3 in the cycle after the accepting edge; port 4, first bit in the cycle after the ACK edge; BUSY back to 0 one cycle after the last bit.
REQ-025 Lo3, READY and SER_VALID SHALL never be high in the same cycle.

Reset
REQ-026 CLR=0 SHALL force, immediately and regardless of CLK: state IDLE, Lo3=0, P3_DATA=00h, READY=0, SER_OUT=1, SER_VALID=0, BUSY=0, TIMEOUT=0, count=0, data register=00h.
REQ-027 Reset during SHIFT or WAIT_ACK SHALL abandon the byte, with no partial bits output after release.
REQ-028 After CLR returns to 1, the first rising edge SHALL be able to accept a request.

Configuration
REQ-029 Macro OUT_TIMEOUT_EN SHALL enable the ACK watchdog.
REQ-030 With OUT_TIMEOUT_EN defined, a cycle counter SHALL run in WAIT_ACK; on reaching TO_CYCLES without ACK, the next state SHALL be IDLE and TIMEOUT SHALL be set to 1.
REQ-031 If ACK=1 on the same edge the counter reaches TO_CYCLES, ACK SHALL win: go to SHIFT, TIMEOUT unchanged.
REQ-032 TIMEOUT SHALL be cleared on the next accepted OUT_req.
REQ-033 With OUT_TIMEOUT_EN undefined, WAIT_ACK SHALL wait indefinitely, TIMEOUT SHALL be tied to 0, and no counter logic SHALL be present.

Verification
REQ-034 OUT_req=1, PORT_sel=0, WBUS=A5h -> Lo3=1 for exactly one cycle, P3_DATA=A5h, BUSY high for 1 cycle.
REQ-035 OUT_req=1, PORT_sel=1, WBUS=B4h, ACK after 3 cycles -> READY high 3 cycles, then SER_OUT=0,0,1,0,1,1,0,1 with SER_VALID high 8 cycles, then BUSY=0.
REQ-036 Port 4 byte in SHIFT plus OUT_req=1 with PORT_sel=0 and WBUS=FFh -> request ignored, Lo3 stays 0, P3_DATA unchanged.
REQ-037 CLR=0 asserted between clock edges mid-SHIFT (bit 4) -> all outputs at reset values before the next edge, SER_OUT=1, no further bits.
REQ-038 With OUT_TIMEOUT_EN and TO_CYCLES=4, a port 4 request with no ACK -> IDLE after 4 WAIT_ACK cycles with TIMEOUT=1, cleared by the next accepted request.
REQ-039 With OUT_TIMEOUT_EN, ACK arriving on the terminal-count edge -> SHIFT entered and TIMEOUT remains 0.

Source files
------------

// File: rtl/out_port_ctrl.sv
// Output-port controller: one-shot hex load on port 3, ACK-handshaked LSB-first serial byte on port 4.
// Optional ACK watchdog enabled by defining OUT_TIMEOUT_EN (parameter TO_CYCLES sets its limit).
module out_port_ctrl #(
    parameter int TO_CYCLES = 255
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [7:0] WBUS,
    input  logic       OUT_req,
    input  logic       PORT_sel,
    input  logic       ACK,
    output logic       Lo3,
    output logic [7:0] P3_DATA,
    output logic       READY,
    output logic       SER_OUT,
    output logic       SER_VALID,
    output logic       BUSY,
    output logic       TIMEOUT
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD3,
        WAIT_ACK,
        SHIFT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] data_reg;
    logic [7:0] p3_reg;
    logic [2:0] count;
    logic       accept;
    logic       to_hit;

    assign accept = (state == IDLE) && OUT_req;

`ifdef OUT_TIMEOUT_EN
    localparam int TW = (TO_CYCLES < 2) ? 1 : $clog2(TO_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic          timeout_reg;

    // to_cnt counts completed WAIT_ACK cycles; the terminal edge is the TO_CYCLES-th one
    assign to_hit = (state == WAIT_ACK) && (to_cnt == TW'(TO_CYCLES - 1));

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            to_cnt      <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (state == WAIT_ACK) begin
                to_cnt <= to_cnt + TW'(1);
            end else begin
                to_cnt <= '0;
            end
            if (accept) begin
                timeout_reg <= 1'b0;
            end else if (to_hit && !ACK) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign TIMEOUT = timeout_reg;
`else
    localparam int unused_to_cycles = TO_CYCLES;

    assign to_hit  = 1'b0;
    assign TIMEOUT = 1'b0;
`endif

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture happens only on an accepted request; port 3 keeps its own copy so it
    // holds across later port-4 traffic.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            data_reg <= 8'h00;
            p3_reg   <= 8'h00;
            count    <= 3'd0;
        end else begin
            if (accept) begin
                data_reg <= WBUS;
                if (!PORT_sel) begin
                    p3_reg <= WBUS;
                end
            end
            if (state == SHIFT) begin
                count <= count + 3'd1;
            end else begin
                count <= 3'd0;
            end
        end
    end

    always_comb begin
        state_next = state;
        Lo3        = 1'b0;
        READY      = 1'b0;
        SER_OUT    = 1'b1;
        SER_VALID  = 1'b0;
        BUSY       = (state != IDLE);
        case (state)
            IDLE: begin
                if (OUT_req) begin
                    state_next = PORT_sel ? WAIT_ACK : LOAD3;
                end
            end
            LOAD3: begin
                Lo3        = 1'b1;
                state_next = IDLE;
            end
            WAIT_ACK: begin
                READY = 1'b1;
                // ACK takes priority over the watchdog on the terminal edge
                if (ACK) begin
                    state_next = SHIFT;
                end else if (to_hit) begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                SER_VALID = 1'b1;
                SER_OUT   = data_reg[count];
                if (count == 3'd7) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign P3_DATA = p3_reg;

endmodule

// File: tb/tb_out_port_ctrl.sv
// Scoreboard bench for out_port_ctrl: expected per-cycle output vectors are queued as stimulus is driven.
module tb_out_port_ctrl;

    logic       CLK = 1'b0;
    logic       CLR;
    logic [7:0] WBUS;
    logic       OUT_req;
    logic       PORT_sel;
    logic       ACK;
    logic       Lo3;
    logic [7:0] P3_DATA;
    logic       READY;
    logic       SER_OUT;
    logic       SER_VALID;
    logic       BUSY;
    logic       TIMEOUT;

    logic [13:0] exp_q[$];
    int          num_checks = 0;
    int          num_passed = 0;

    out_port_ctrl #(.TO_CYCLES(4)) dut (
        .CLK(CLK), .CLR(CLR), .WBUS(WBUS), .OUT_req(OUT_req), .PORT_sel(PORT_sel), .ACK(ACK),
        .Lo3(Lo3), .P3_DATA(P3_DATA), .READY(READY), .SER_OUT(SER_OUT),
        .SER_VALID(SER_VALID), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    // Vector layout: {Lo3, P3_DATA, READY, SER_OUT, SER_VALID, BUSY, TIMEOUT}
    function automatic logic [13:0] pk(input logic lo3, input logic [7:0] p3, input logic ready,
                                       input logic so, input logic sv, input logic busy, input logic to);
        return {lo3, p3, ready, so, sv, busy, to};
    endfunction

    function automatic logic [13:0] idle_v(input logic [7:0] p3, input logic to);
        return pk(1'b0, p3, 1'b0, 1'b1, 1'b0, 1'b0, to);
    endfunction

    function automatic logic [13:0] load_v(input logic [7:0] p3, input logic to);
        return pk(1'b1, p3, 1'b0, 1'b1, 1'b0, 1'b1, to);
    endfunction

    function automatic logic [13:0] wait_v(input logic [7:0] p3, input logic to);
        return pk(1'b0, p3, 1'b1, 1'b1, 1'b0, 1'b1, to);
    endfunction

    function automatic logic [13:0] shift_v(input logic [7:0] p3, input logic b, input logic to);
        return pk(1'b0, p3, 1'b0, b, 1'b1, 1'b1, to);
    endfunction

    function automatic logic [13:0] observed();
        return {Lo3, P3_DATA, READY, SER_OUT, SER_VALID, BUSY, TIMEOUT};
    endfunction

    task automatic checkOutput(input string tag, input logic [13:0] got, input logic [13:0] exp);
        num_checks++;
        if (got === exp) begin
            num_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs after the next edge, then compare.
    task automatic applyStimulus(input string tag, input logic req, input logic sel,
                                 input logic [7:0] w, input logic ack, input logic [13:0] exp);
        OUT_req  = req;
        PORT_sel = sel;
        WBUS     = w;
        ACK      = ack;
        exp_q.push_back(exp);
        @(posedge CLK);
        #1;
        checkOutput(tag, observed(), exp_q.pop_front());
    endtask

    // Port-4 byte: ACK held high during the accepting edge (must be ignored), READY for
    // 'waits' cycles, then 8 bits while a port-3 request for FFh is pressed (must be ignored).
    task automatic send_port4(input string tag, input logic [7:0] d, input int waits,
                              input logic [7:0] p3, input logic to_before);
        applyStimulus({tag, "_accept"}, 1'b1, 1'b1, d, 1'b1, wait_v(p3, 1'b0));
        for (int i = 1; i < waits; i++) begin
            applyStimulus({tag, "_wait"}, 1'b0, 1'b0, 8'h00, 1'b0, wait_v(p3, 1'b0));
        end
        applyStimulus({tag, "_bit0"}, 1'b0, 1'b0, 8'h00, 1'b1, shift_v(p3, d[0], 1'b0));
        for (int i = 1; i < 8; i++) begin
            applyStimulus({tag, "_bit"}, 1'b1, 1'b0, 8'hFF, 1'b1, shift_v(p3, d[i], 1'b0));
        end
        applyStimulus({tag, "_done"}, 1'b0, 1'b0, 8'h00, 1'b0, idle_v(p3, 1'b0));
        if (to_before) begin
            $display("[TB] note: %s started with TIMEOUT set", tag);
        end
    endtask

    initial begin
        logic [7:0] d;
        CLR      = 1'b0;
        OUT_req  = 1'b0;
        PORT_sel = 1'b0;
        WBUS     = 8'h00;
        ACK      = 1'b0;
        #2;
        checkOutput("reset_state", observed(), idle_v(8'h00, 1'b0));
        @(negedge CLK);
        CLR = 1'b1;

        applyStimulus("idle_ack", 1'b0, 1'b0, 8'h00, 1'b1, idle_v(8'h00, 1'b0));

        applyStimulus("p3_accept", 1'b1, 1'b0, 8'hA5, 1'b0, load_v(8'hA5, 1'b0));
        applyStimulus("p3_done", 1'b0, 1'b0, 8'h00, 1'b0, idle_v(8'hA5, 1'b0));

        send_port4("p4_b4", 8'hB4, 3, 8'hA5, 1'b0);

`ifndef OUT_TIMEOUT_EN
        send_port4("p4_long", 8'h81, 12, 8'hA5, 1'b0);
`endif

        // Reset pulled mid-byte, between edges, while bit 4 is on the line
        d = 8'h3C;
        applyStimulus("rst_accept", 1'b1, 1'b1, d, 1'b0, wait_v(8'hA5, 1'b0));
        applyStimulus("rst_bit0", 1'b0, 1'b0, 8'h00, 1'b1, shift_v(8'hA5, d[0], 1'b0));
        for (int i = 1; i < 5; i++) begin
            applyStimulus("rst_bit", 1'b0, 1'b0, 8'h00, 1'b0, shift_v(8'hA5, d[i], 1'b0));
        end
        #3;
        CLR = 1'b0;
        #1;
        checkOutput("reset_midshift", observed(), idle_v(8'h00, 1'b0));
        applyStimulus("reset_held", 1'b0, 1'b0, 8'h00, 1'b0, idle_v(8'h00, 1'b0));
        CLR = 1'b1;
        applyStimulus("release_accept", 1'b1, 1'b0, 8'h5A, 1'b0, load_v(8'h5A, 1'b0));
        applyStimulus("release_idle", 1'b0, 1'b0, 8'h00, 1'b0, idle_v(8'h5A, 1'b0));

`ifdef OUT_TIMEOUT_EN
        applyStimulus("to_accept", 1'b1, 1'b1, 8'h55, 1'b0, wait_v(8'h5A, 1'b0));
        for (int i = 1; i < 4; i++) begin
            applyStimulus("to_wait", 1'b0, 1'b0, 8'h00, 1'b0, wait_v(8'h5A, 1'b0));
        end
        applyStimulus("to_expire", 1'b0, 1'b0, 8'h00, 1'b0, idle_v(8'h5A, 1'b1));
        applyStimulus("to_sticky", 1'b0, 1'b0, 8'h00, 1'b1, idle_v(8'h5A, 1'b1));
        applyStimulus("to_clear", 1'b1, 1'b0, 8'h77, 1'b0, load_v(8'h77, 1'b0));
        applyStimulus("to_clear_idle", 1'b0, 1'b0, 8'h00, 1'b0, idle_v(8'h77, 1'b0));
        send_port4("to_ackwin", 8'hC3, 4, 8'h77, 1'b0);
`endif

        $display("%0d/%0d checks passed", num_passed, num_checks);
        $finish;
    end

endmodule
